// File: rtl/multdiv_arbiter_if.sv
// Signal bundle of multdiv_arbiter: two requester ports, the multdiv unit side
// and the tagged response. The slave view belongs to the arbiter.
interface multdiv_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic             req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;

    logic [WIDTH-1:0] md_operandA;
    logic [WIDTH-1:0] md_operandB;
    logic             md_ctrl_MULT;
    logic             md_ctrl_DIV;
    logic [WIDTH-1:0] md_result;
    logic             md_exception;
    logic             md_resultRDY;

    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_exception;
    logic             rsp_timeout;
    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  md_result, md_exception, md_resultRDY,
        output req0_ready, req1_ready,
        output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        output rsp_valid, rsp_id, rsp_result, rsp_exception, rsp_timeout, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output md_result, md_exception, md_resultRDY,
        input  req0_ready, req1_ready,
        input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        input  rsp_valid, rsp_id, rsp_result, rsp_exception, rsp_timeout, busy
    );
endinterface

// File: rtl/multdiv_arbiter.sv
// Round-robin arbiter sharing one multdiv unit between two requesters: latches the
// winner's request, pulses the multdiv start, waits for ready or watchdog, returns a tagged response.
module multdiv_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input logic              clock,
    input logic              reset_n,
    multdiv_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;

    typedef struct packed {
        logic             id;
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] result;
        logic             exception;
        logic             timeout;
    } rsp_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    req_t       req_q, req_d;
    rsp_t       rsp_q, rsp_d;
    logic       grant0, grant1;

    // With both valid, the requester that was not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        req_d        = req_q;
        rsp_d        = rsp_q;

        unique case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    req_d.id = grant1;
                    req_d.op = grant1 ? bus.req1_op : bus.req0_op;
                    req_d.a  = grant1 ? bus.req1_a  : bus.req0_a;
                    req_d.b  = grant1 ? bus.req1_b  : bus.req0_b;
                    state_d  = START;
                end
            end

            START: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end

            WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                // In the first WAIT cycle multdiv is still restarting; its ready is stale.
                if ((wait_cnt_q != 8'd0) && bus.md_resultRDY) begin
                    rsp_d.id        = req_q.id;
                    rsp_d.result    = bus.md_result;
                    rsp_d.exception = bus.md_exception;
                    rsp_d.timeout   = 1'b0;
                    state_d         = RESP;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    rsp_d.id        = req_q.id;
                    rsp_d.result    = '0;
                    rsp_d.exception = 1'b1;
                    rsp_d.timeout   = 1'b1;
                    state_d         = RESP;
                end
            end

            RESP: begin
                last_grant_d = req_q.id;
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= '0;
            req_q        <= '0;
            rsp_q        <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            req_q        <= req_d;
            rsp_q        <= rsp_d;
        end
    end

    assign bus.md_operandA   = req_q.a;
    assign bus.md_operandB   = req_q.b;
    assign bus.md_ctrl_MULT  = (state_q == START) && !req_q.op;
    assign bus.md_ctrl_DIV   = (state_q == START) &&  req_q.op;

    assign bus.rsp_valid     = (state_q == RESP);
    assign bus.rsp_id        = rsp_q.id;
    assign bus.rsp_result    = rsp_q.result;
    assign bus.rsp_exception = rsp_q.exception;
    assign bus.rsp_timeout   = rsp_q.timeout;
    assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Directed and randomized bench for multdiv_arbiter with a behavioural multdiv stub
// of programmable latency and a transaction-level arbitration/latency model.
module tb_multdiv_arbiter;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 64;

    logic clock;
    logic reset_n;

    multdiv_arbiter_if #(.WIDTH(WIDTH)) bus ();

    multdiv_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;

    int mult_pulses = 0;
    int div_pulses  = 0;
    int both_pulses = 0;
    int ready_viol  = 0;

    int stub_lat = 2;

    logic        r_op [2];
    logic [31:0] r_a  [2];
    logic [31:0] r_b  [2];
    bit          lg_m;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Reference multdiv arithmetic: low-word product, signed quotient, divide by zero flags.
    function automatic void md_compute(input bit op, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] r, output bit exc);
        exc = 1'b0;
        if (!op) r = a * b;
        else if (b == 32'd0) begin
            r   = 32'd0;
            exc = 1'b1;
        end else r = $signed(a) / $signed(b);
    endfunction

    // multdiv stub: a start pulse restarts it; ready pulses stub_lat cycles later (0 = never).
    initial begin
        int          cnt;
        logic [31:0] res;
        bit          exc;
        cnt = 0;
        res = '0;
        exc = 1'b0;
        bus.md_resultRDY = 1'b0;
        bus.md_result    = '0;
        bus.md_exception = 1'b0;
        forever begin
            @(negedge clock);
            bus.md_resultRDY = 1'b0;
            bus.md_result    = $urandom;
            bus.md_exception = 1'($urandom_range(0, 1));
            if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) begin
                cnt = stub_lat;
                md_compute(bus.md_ctrl_DIV, bus.md_operandA, bus.md_operandB, res, exc);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.md_resultRDY = 1'b1;
                    bus.md_result    = res;
                    bus.md_exception = exc;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (bus.md_ctrl_MULT) mult_pulses++;
            if (bus.md_ctrl_DIV)  div_pulses++;
            if (bus.md_ctrl_MULT && bus.md_ctrl_DIV) both_pulses++;
            if (bus.req0_ready && bus.req1_ready) ready_viol++;
            if (bus.busy && (bus.req0_ready || bus.req1_ready)) ready_viol++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues the selected requests (hold = both stay valid for four grants) and checks
    // grant order, results, flags and accept-to-response latency against the model.
    task automatic run_batch(input bit use0, input bit use1, input int lat, input bit hold);
        bit          exp_ids[$];
        int          acc_cyc [2];
        bit          drop [2];
        int          got, want, n_mult, n_div, m0, d0, exp_lat;
        bit          nxt, timed_out, last_id;
        logic [31:0] er, last_res;
        bit          ee;

        want   = hold ? 4 : (int'(use0) + int'(use1));
        nxt    = (use0 && use1) ? !lg_m : use1;
        n_mult = 0;
        n_div  = 0;
        for (int k = 0; k < want; k++) begin
            exp_ids.push_back(nxt);
            if (r_op[nxt]) n_div++;
            else n_mult++;
            if (use0 && use1) nxt = !nxt;
        end
        timed_out = !(lat >= 2 && lat <= TIMEOUT);
        exp_lat   = timed_out ? TIMEOUT + 1 : lat + 1;

        stub_lat   = lat;
        m0         = mult_pulses;
        d0         = div_pulses;
        got        = 0;
        acc_cyc    = '{0, 0};
        drop       = '{1'b0, 1'b0};
        last_id    = 1'b0;
        last_res   = '0;

        @(negedge clock);
        bus.req0_valid = use0;
        bus.req0_op    = r_op[0];
        bus.req0_a     = r_a[0];
        bus.req0_b     = r_b[0];
        bus.req1_valid = use1;
        bus.req1_op    = r_op[1];
        bus.req1_a     = r_a[1];
        bus.req1_b     = r_b[1];

        for (int t = 0; t < 600 && got < want; t++) begin
            #1;
            if (bus.rsp_valid) begin
                bit id;
                id = exp_ids[got];
                md_compute(r_op[id], r_a[id], r_b[id], er, ee);
                if (timed_out) begin
                    er = 32'd0;
                    ee = 1'b1;
                end
                check("rsp_id",        bus.rsp_id,        id);
                check("rsp_result",    bus.rsp_result,    er);
                check("rsp_exception", bus.rsp_exception, ee);
                check("rsp_timeout",   bus.rsp_timeout,   timed_out);
                check("latency",       cyc - acc_cyc[id], exp_lat);
                lg_m     = id;
                last_id  = id;
                last_res = er;
                got++;
            end
            if (got < want) begin
                if (bus.req0_valid && bus.req0_ready) begin
                    acc_cyc[0] = cyc + 1;
                    drop[0]    = !hold;
                end
                if (bus.req1_valid && bus.req1_ready) begin
                    acc_cyc[1] = cyc + 1;
                    drop[1]    = !hold;
                end
                @(negedge clock);
                if (drop[0]) bus.req0_valid = 1'b0;
                if (drop[1]) bus.req1_valid = 1'b0;
                drop = '{1'b0, 1'b0};
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        check("batch_responses", got, want);
        check("mult_pulses", mult_pulses - m0, n_mult);
        check("div_pulses",  div_pulses - d0,  n_div);

        @(negedge clock);
        #1;
        check("rsp_valid_one_cycle", bus.rsp_valid, 1'b0);
        check("idle_after_resp",     bus.busy,      1'b0);
        check("rsp_id_hold",         bus.rsp_id,    last_id);
        check("rsp_result_hold",     bus.rsp_result, last_res);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("reset_busy", bus.busy, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        lg_m    = 1'b1;
    endtask

    initial begin
        int seen;

        reset_n        = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_op    = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_op    = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        lg_m           = 1'b1;

        repeat (2) @(negedge clock);
        #1;
        check("rst_busy",      bus.busy,        1'b0);
        check("rst_rsp_flags", {bus.rsp_valid, bus.rsp_id, bus.rsp_exception, bus.rsp_timeout}, 4'b0);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        check("rst_operands",  {bus.md_operandA, bus.md_operandB}, 64'd0);
        check("rst_ctrl",      {bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 2'b0);
        check("rst_ready",     {bus.req0_ready, bus.req1_ready}, 2'b0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed vectors
        r_op[0] = 1'b0; r_a[0] = 32'd2;   r_b[0] = 32'hFFFF_FFFC;
        run_batch(1'b1, 1'b0, $urandom_range(2, 8), 1'b0);
        check("t1_result", bus.rsp_result, 32'hFFFF_FFF8);

        r_op[1] = 1'b1; r_a[1] = 32'd100; r_b[1] = 32'd7;
        run_batch(1'b0, 1'b1, $urandom_range(2, 8), 1'b0);
        check("t2_result", bus.rsp_result, 32'd14);
        check("t2_id",     bus.rsp_id,     1'b1);

        r_op[1] = 1'b1; r_a[1] = 32'd5;   r_b[1] = 32'd0;
        run_batch(1'b0, 1'b1, 3, 1'b0);
        check("t3_flags", {bus.rsp_exception, bus.rsp_timeout}, 2'b10);

        do_reset();
        r_op[0] = 1'b0; r_a[0] = 32'd3; r_b[0] = 32'd5;
        r_op[1] = 1'b0; r_a[1] = 32'd6; r_b[1] = 32'd7;
        run_batch(1'b1, 1'b1, 4, 1'b1);
        check("t4_last", bus.rsp_result, 32'd42);

        r_op[0] = 1'b0; r_a[0] = 32'd9; r_b[0] = 32'd9;
        run_batch(1'b1, 1'b0, 0, 1'b0);
        check("t5_flags", {bus.rsp_exception, bus.rsp_timeout, bus.rsp_result}, {2'b11, 32'd0});
        run_batch(1'b1, 1'b0, 4, 1'b0);
        check("t5_recover", bus.rsp_result, 32'd81);

        // Ready during the restart cycle only -> ignored -> watchdog; ready on the last cycle wins.
        r_op[1] = 1'b1; r_a[1] = 32'd50; r_b[1] = 32'd5;
        run_batch(1'b0, 1'b1, 1, 1'b0);
        run_batch(1'b0, 1'b1, TIMEOUT, 1'b0);
        run_batch(1'b0, 1'b1, 2, 1'b0);

        // Reset while waiting on a hung multdiv
        stub_lat = 0;
        @(negedge clock);
        bus.req0_valid = 1'b1;
        bus.req0_op    = 1'b0;
        bus.req0_a     = 32'd2;
        bus.req0_b     = 32'hFFFF_FFFC;
        #1;
        check("t6_ready", bus.req0_ready, 1'b1);
        @(negedge clock);
        bus.req0_valid = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("t6_busy_wait", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_busy",     bus.busy, 1'b0);
        check("t6_rst_operands", {bus.md_operandA, bus.md_operandB}, 64'd0);
        check("t6_rst_ctrl_rsp", {bus.md_ctrl_MULT, bus.md_ctrl_DIV, bus.rsp_valid}, 3'b0);
        @(negedge clock);
        reset_n = 1'b1;
        lg_m    = 1'b1;
        seen    = 0;
        repeat (6) begin
            @(negedge clock);
            #1;
            if (bus.rsp_valid) seen++;
        end
        check("t6_no_rsp", seen, 0);
        r_op[0] = 1'b0; r_a[0] = 32'd2; r_b[0] = 32'hFFFF_FFFC;
        run_batch(1'b1, 1'b0, 3, 1'b0);
        check("t6_result", bus.rsp_result, 32'hFFFF_FFF8);

        // Randomized requester mixes, operands and multdiv latencies
        for (int k = 0; k < 12; k++) begin
            int u, sel, lat;
            u = int'($urandom_range(1, 3));
            for (int j = 0; j < 2; j++) begin
                r_op[j] = 1'($urandom_range(0, 1));
                r_a[j]  = $urandom;
                r_b[j]  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            end
            sel = int'($urandom_range(0, 15));
            lat = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? TIMEOUT : int'($urandom_range(2, 12));
            run_batch(u[0], u[1], lat, 1'b0);
        end

        check("ctrl_never_both", both_pulses, 0);
        check("ready_rules",     ready_viol,  0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
